pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register. It generalises the fixed IF/ID latch to any payload width. It replaces the level write-enable with a valid/ready handshake and adds a one-entry skid buffer, so upstream ready is fully registered and never depends combinationally on downstream ready. It sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB), and the hazard unit drives its flush.

Parameters:
DATA_W, 64, payload width in bits (e.g. pcplus4 concatenated with instr for IF/ID).
FLUSH_CLR, 1, 1 = flush zeroes stored data; 0 = flush only clears valid bits, data held.
CNT_W, 32, width of statistics counters (used only with PIPE_STAGE_STATS_EN).

Ports:
CLK  input  1  clock, rising edge
nRST  input  1  reset, asynchronous, active-low
in_valid  input  1  upstream presents in_data
in_ready  output  1  stage can accept; registered (function of skid_valid only)
in_data  input  DATA_W  upstream payload
flush  input  1  synchronous squash of all held entries
out_valid  output  1  out_data valid for downstream
out_ready  input  1  downstream accepts out_data this cycle
out_data  output  DATA_W  payload of the main entry (registered)
occupancy  output  2  entries held: 0, 1 or 2
stall_cycles  output  CNT_W  only with PIPE_STAGE_STATS_EN
bubble_cycles  output  CNT_W  only with PIPE_STAGE_STATS_EN
flush_count  output  CNT_W  only with PIPE_STAGE_STATS_EN

Behaviour:
- Storage: main entry {main_valid, main_data} drives out_valid/out_data. Skid entry {skid_valid, skid_data}.
- Transfer definitions:
  - acc = in_valid & in_ready
  - drn = out_valid & out_ready
- in_ready = !skid_valid. It is derived from the register, so there is no combinational path from out_ready.
- occupancy = main_valid + skid_valid.
- States and transitions:
  - EMPTY (occ 0), the only state where in_ready=1 and out_valid=0:
    - acc -> HALF, main<=in_data.
    - no acc -> EMPTY.
  - HALF (occ 1):
    - acc & drn -> HALF, main<=in_data.
    - acc & !drn -> FULL, skid<=in_data, main unchanged.
    - !acc & drn -> EMPTY.
    - neither -> HALF, hold.
  - FULL (occ 2), in_ready=0 so acc is impossible:
    - drn -> HALF, main<=skid, skid_valid<=0.
    - !drn -> hold.
- Latency: 1 cycle from acc in EMPTY to out_valid=1. Throughput is 1 transfer/cycle with out_ready held high.
- Order: strict FIFO; no payload is dropped or duplicated except by flush.
- Stability: while out_valid & !out_ready, out_data and out_valid must not change (except flush/reset).
- Flush: synchronous, highest priority over acc and drn.
  - Next cycle: main_valid=0, skid_valid=0, occ=0, in_ready=1.
  - An in_data accepted in the flush cycle is discarded.
  - A drn in the flush cycle still completes downstream; the downstream stage must qualify its own flush.
  - FLUSH_CLR=1: main_data and skid_data <= 0 (instr 0 = nop).
  - FLUSH_CLR=0: data registers hold.
- Reset: asynchronous, effective mid-operation.
  - All valid bits 0, all data 0, out_valid=0, occupancy=0, in_ready=1 while nRST low and after release.
  - Statistics counters are 0.
- X-safety: in_data is ignored when in_valid=0. out_ready is ignored when out_valid=0.

Optional Feature:
PIPE_STAGE_STATS_EN.
- Defined:
  - stall_cycles increments each cycle out_valid & !out_ready.
  - bubble_cycles increments each cycle !out_valid.
  - flush_count increments each cycle flush=1.
  - All three saturate at all-ones. They are cleared only by nRST, not by flush.
  - Counters update on the same edge as the event cycle.
- Not defined: the three ports and their logic are absent. Datapath behaviour is identical.

Test Plan:
- Reset mid-FULL: fill with 0xA, 0xB, out_ready=0, assert nRST low -> out_valid=0, occupancy=0, in_ready=1, out_data=0 immediately (async).
- Streaming: in_valid=1, out_ready=1, data 1..8 back-to-back -> out_data 1..8 on consecutive cycles, 1-cycle latency, in_ready stays 1, occupancy=1 throughout.
- Backpressure/skid: send 0x11, 0x22 with out_ready=0 -> occupancy=2, in_ready=0, out_data=0x11 held. Raise out_ready -> 0x11 then 0x22 on consecutive cycles, in_ready=1 the cycle after the first drain.
- Flush priority: FULL with 0x33/0x44, assert flush with in_valid=1 (0x55) and out_ready=0 -> next cycle occupancy=0, out_valid=0, out_data=0 (FLUSH_CLR=1); 0x55 never appears on the output.
- FLUSH_CLR=0 variant: same stimulus -> out_valid=0, out_data still 0x33.
- Stats (PIPE_STAGE_STATS_EN, CNT_W=4): 20 stall cycles -> stall_cycles=15 (saturated); 3 flushes -> flush_count=3; reset -> all counters 0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, one-entry skid buffer and synchronous flush.
// Optional saturating statistics counters are enabled by defining PIPE_STAGE_STATS_EN.
module pipe_stage_reg #(
   parameter int DATA_W    = 64,
   parameter int FLUSH_CLR = 1,
   parameter int CNT_W     = 32
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
`ifdef PIPE_STAGE_STATS_EN
   ,
   output logic [CNT_W-1:0]  stall_cycles,
   output logic [CNT_W-1:0]  bubble_cycles,
   output logic [CNT_W-1:0]  flush_count
`endif
);

   logic              main_valid_q, main_valid_d;
   logic              skid_valid_q, skid_valid_d;
   logic [DATA_W-1:0] main_data_q, main_data_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic              acc;
   logic              drn;

   // in_ready comes straight from a flop so out_ready never reaches upstream combinationally.
   assign in_ready  = !skid_valid_q;
   assign out_valid = main_valid_q;
   assign out_data  = main_data_q;
   assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

   assign acc = in_valid & in_ready;
   assign drn = main_valid_q & out_ready;

   always_comb begin
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      main_data_d  = main_data_q;
      skid_data_d  = skid_data_q;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
         if (FLUSH_CLR != 0) begin
            main_data_d = '0;
            skid_data_d = '0;
         end
      end else begin
         case ({main_valid_q, skid_valid_q})
            2'b00: begin
               if (acc) begin
                  main_valid_d = 1'b1;
                  main_data_d  = in_data;
               end
            end
            2'b10: begin
               if (acc && drn) begin
                  main_data_d = in_data;
               end else if (acc) begin
                  skid_valid_d = 1'b1;
                  skid_data_d  = in_data;
               end else if (drn) begin
                  main_valid_d = 1'b0;
               end
            end
            2'b11: begin
               if (drn) begin
                  main_data_d  = skid_data_q;
                  skid_valid_d = 1'b0;
               end
            end
            default: begin
               // Skid without main is unreachable; recover to empty.
               main_valid_d = 1'b0;
               skid_valid_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         main_data_q  <= '0;
         skid_data_q  <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         main_data_q  <= main_data_d;
         skid_data_q  <= skid_data_d;
      end
   end

`ifdef PIPE_STAGE_STATS_EN
   logic [CNT_W-1:0] stall_q;
   logic [CNT_W-1:0] bubble_q;
   logic [CNT_W-1:0] flush_cnt_q;

   // Counters saturate at all-ones and are cleared only by reset, never by flush.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stall_q     <= '0;
         bubble_q    <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (main_valid_q && !out_ready && (stall_q != '1))
            stall_q <= stall_q + CNT_W'(1);
         if (!main_valid_q && (bubble_q != '1))
            bubble_q <= bubble_q + CNT_W'(1);
         if (flush && (flush_cnt_q != '1))
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   assign stall_cycles  = stall_q;
   assign bubble_cycles = bubble_q;
   assign flush_count   = flush_cnt_q;
`else
   if (CNT_W < 1) begin : g_cnt_w_chk
      $error("CNT_W must be at least 1");
   end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus randomized traffic against a queue model.
// Two instances share stimulus, one with FLUSH_CLR=1 and one with FLUSH_CLR=0.
module tb_pipe_stage_reg;
   localparam int DW    = 16;
   localparam int CW    = 4;
   localparam int CMAX  = (1 << CW) - 1;

   logic          CLK = 1'b0;
   logic          nRST;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          flush;
   logic          out_ready;

   logic          in_ready1, out_valid1, in_ready0, out_valid0;
   logic [DW-1:0] out_data1, out_data0;
   logic [1:0]    occ1, occ0;
`ifdef PIPE_STAGE_STATS_EN
   logic [CW-1:0] stall1, bubble1, fcnt1, stall0, bubble0, fcnt0;
`endif

   int nvec = 0;
   int nerr = 0;

   always #5 CLK = ~CLK;

   pipe_stage_reg #(.DATA_W(DW), .FLUSH_CLR(1), .CNT_W(CW)) dut1 (
      .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
      .flush(flush), .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
      .occupancy(occ1)
`ifdef PIPE_STAGE_STATS_EN
      , .stall_cycles(stall1), .bubble_cycles(bubble1), .flush_count(fcnt1)
`endif
   );

   pipe_stage_reg #(.DATA_W(DW), .FLUSH_CLR(0), .CNT_W(CW)) dut0 (
      .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
      .flush(flush), .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
      .occupancy(occ0)
`ifdef PIPE_STAGE_STATS_EN
      , .stall_cycles(stall0), .bubble_cycles(bubble0), .flush_count(fcnt0)
`endif
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: the stage is a FIFO of at most two entries.
   logic [DW-1:0] q[$];
   int m_stall, m_bubble, m_flush;

   always @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         q.delete();
         m_stall  = 0;
         m_bubble = 0;
         m_flush  = 0;
      end else begin
         automatic bit acc = in_valid && (q.size() < 2);
         automatic bit drn = (q.size() > 0) && out_ready;
         if (q.size() > 0 && !out_ready && m_stall < CMAX) m_stall++;
         if (q.size() == 0 && m_bubble < CMAX) m_bubble++;
         if (flush && m_flush < CMAX) m_flush++;
         if (flush) begin
            q.delete();
         end else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(in_data);
         end
      end
   end

   always @(negedge CLK) begin
      if (nRST) begin
         chk("out_valid1", 64'(out_valid1), 64'(q.size() > 0));
         chk("out_valid0", 64'(out_valid0), 64'(q.size() > 0));
         chk("in_ready1", 64'(in_ready1), 64'(q.size() < 2));
         chk("in_ready0", 64'(in_ready0), 64'(q.size() < 2));
         chk("occupancy1", 64'(occ1), 64'(q.size()));
         chk("occupancy0", 64'(occ0), 64'(q.size()));
         if (q.size() > 0) begin
            chk("out_data1", 64'(out_data1), 64'(q[0]));
            chk("out_data0", 64'(out_data0), 64'(q[0]));
         end
`ifdef PIPE_STAGE_STATS_EN
         chk("stall_cycles", 64'(stall1), 64'(m_stall));
         chk("bubble_cycles", 64'(bubble1), 64'(m_bubble));
         chk("flush_count", 64'(fcnt1), 64'(m_flush));
         chk("stall_cycles0", 64'(stall0), 64'(m_stall));
`endif
      end
   end

   task automatic cyc();
      @(negedge CLK);
   endtask

   task automatic chk_empty_reset(input string tag);
      chk({tag, "_out_valid"}, 64'(out_valid1), 64'd0);
      chk({tag, "_occ"}, 64'(occ1), 64'd0);
      chk({tag, "_in_ready"}, 64'(in_ready1), 64'd1);
      chk({tag, "_out_data1"}, 64'(out_data1), 64'd0);
      chk({tag, "_out_data0"}, 64'(out_data0), 64'd0);
      chk({tag, "_occ0"}, 64'(occ0), 64'd0);
`ifdef PIPE_STAGE_STATS_EN
      chk({tag, "_stall"}, 64'(stall1), 64'd0);
      chk({tag, "_bubble"}, 64'(bubble1), 64'd0);
      chk({tag, "_flush_cnt"}, 64'(fcnt1), 64'd0);
`endif
   endtask

   initial begin
      nRST = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
      #12;
      chk_empty_reset("reset");
      #1 nRST = 1'b1;
      cyc();

      // Streaming 1..8 with one-cycle latency
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1;
         in_data  = DW'(i);
         cyc();
         chk("stream_data", 64'(out_data1), 64'(i));
         chk("stream_valid", 64'(out_valid1), 64'd1);
         chk("stream_occ", 64'(occ1), 64'd1);
         chk("stream_ready", 64'(in_ready1), 64'd1);
      end
      in_valid = 1'b0;
      cyc();
      chk("stream_drained", 64'(occ1), 64'd0);

      // Backpressure into the skid entry
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 16'h0011;
      cyc();
      in_data = 16'h0022;
      cyc();
      in_valid = 1'b0;
      chk("skid_occ", 64'(occ1), 64'd2);
      chk("skid_ready", 64'(in_ready1), 64'd0);
      chk("skid_head", 64'(out_data1), 64'h11);
      cyc();
      chk("skid_hold", 64'(out_data1), 64'h11);
      out_ready = 1'b1;
      cyc();
      chk("skid_second", 64'(out_data1), 64'h22);
      chk("skid_ready_after", 64'(in_ready1), 64'd1);
      chk("skid_occ_after", 64'(occ1), 64'd1);
      cyc();
      chk("skid_empty", 64'(out_valid1), 64'd0);

      // Flush beats a simultaneous accept while FULL
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 16'h0033;
      cyc();
      in_data = 16'h0044;
      cyc();
      flush = 1'b1; in_data = 16'h0055;
      cyc();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_occ", 64'(occ1), 64'd0);
      chk("flush_valid", 64'(out_valid1), 64'd0);
      chk("flush_ready", 64'(in_ready1), 64'd1);
      chk("flush_clr_data", 64'(out_data1), 64'd0);
      chk("flush_hold_data", 64'(out_data0), 64'h33);
      out_ready = 1'b1;
      repeat (3) cyc();
      chk("flush_no_55", 64'(out_valid1), 64'd0);

      // Asynchronous reset while FULL
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 16'h000A;
      cyc();
      in_data = 16'h000B;
      cyc();
      in_valid = 1'b0;
      chk("full_before_rst", 64'(occ1), 64'd2);
      #2 nRST = 1'b0;
      #1 chk_empty_reset("async_rst");
      cyc();
      #2 nRST = 1'b1;
      cyc();

`ifdef PIPE_STAGE_STATS_EN
      // Counter saturation, flush counting and reset clearing
      #1 nRST = 1'b0;
      #1 nRST = 1'b1;
      in_valid = 1'b1; in_data = 16'h0077; out_ready = 1'b0;
      cyc();
      in_valid = 1'b0;
      repeat (20) cyc();
      chk("stall_saturated", 64'(stall1), 64'd15);
      flush = 1'b1;
      repeat (3) cyc();
      flush = 1'b0;
      chk("flush_count_3", 64'(fcnt1), 64'd3);
      #1 nRST = 1'b0;
      #1 chk_empty_reset("stats_rst");
      cyc();
      #2 nRST = 1'b1;
      cyc();
`endif

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 4) > 1);
         flush     = ($urandom_range(0, 19) == 0);
         in_data   = DW'($urandom);
         cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
